// File: rtl/ped_request.sv
// Pedestrian push-button request front end: synchronizer, debouncer, request FSM and saturating request counter.
// Optional post-walk lockout phase is built in when PED_LOCKOUT_EN is defined.
module ped_request #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       walk,
  output logic       ped_req,
  output logic       busy,
  output logic [7:0] req_count
);

  localparam int unsigned DB_W  = 4;
  localparam int unsigned LK_W  = 8;
  localparam int unsigned CNT_W = 8;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("ped_request: DEBOUNCE_CYCLES out of range 1..15");
  end
  if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 255) begin : g_bad_lockout
    $error("ped_request: LOCKOUT_CYCLES out of range 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
`ifdef PED_LOCKOUT_EN
    SERVING = 2'd2,
    LOCKOUT = 2'd3
`else
    SERVING = 2'd2
`endif
  } state_e;

  logic             sync1_q, btn_s_q;
  logic             btn_db_q, btn_db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             press_q, press_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] req_count_q, req_count_d;
  logic             ped_req_q, ped_req_d;
  logic             busy_q, busy_d;
`ifdef PED_LOCKOUT_EN
  logic [LK_W-1:0]  lk_cnt_q, lk_cnt_d;
`endif

  // Debounce: accept a level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    press_d = btn_db_d & ~btn_db_q;
  end

  // Request FSM; press_q is registered so the FSM never sees the raw button.
  always_comb begin
    state_d     = state_q;
    req_count_d = req_count_q;
`ifdef PED_LOCKOUT_EN
    lk_cnt_d    = lk_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (press_q) begin
          state_d = walk ? SERVING : PENDING;
          if (req_count_q != {CNT_W{1'b1}}) begin
            req_count_d = req_count_q + CNT_W'(1);
          end
        end
      end
      PENDING: begin
        if (walk) state_d = SERVING;
      end
      SERVING: begin
        if (!walk) begin
`ifdef PED_LOCKOUT_EN
          state_d  = LOCKOUT;
          lk_cnt_d = LK_W'(LOCKOUT_CYCLES);
`else
          state_d  = IDLE;
`endif
        end
      end
`ifdef PED_LOCKOUT_EN
      LOCKOUT: begin
        lk_cnt_d = lk_cnt_q - LK_W'(1);
        if (lk_cnt_q == LK_W'(1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    ped_req_d = (state_d == PENDING);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      btn_s_q     <= 1'b0;
      btn_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      press_q     <= 1'b0;
      state_q     <= IDLE;
      req_count_q <= '0;
      ped_req_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PED_LOCKOUT_EN
      lk_cnt_q    <= '0;
`endif
    end else begin
      sync1_q     <= btn;
      btn_s_q     <= sync1_q;
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      req_count_q <= req_count_d;
      ped_req_q   <= ped_req_d;
      busy_q      <= busy_d;
`ifdef PED_LOCKOUT_EN
      lk_cnt_q    <= lk_cnt_d;
`endif
    end
  end

  assign ped_req   = ped_req_q;
  assign busy      = busy_q;
  assign req_count = req_count_q;

endmodule

// File: tb/tb_ped_request.sv
// Directed self-checking bench for ped_request (default parameters); expectations follow PED_LOCKOUT_EN.
module tb_ped_request;

`ifdef PED_LOCKOUT_EN
  localparam bit LK_EN = 1'b1;
`else
  localparam bit LK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       walk;
  logic       ped_req;
  logic       busy;
  logic [7:0] req_count;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  ped_request dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .walk      (walk),
    .ped_req   (ped_req),
    .busy      (busy),
    .req_count (req_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; walk = 1'b0;
    tick(2);
    rst = 1'b0;
    chk("reset_ped_req", int'(ped_req), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(req_count), 0);

    // Short 3-cycle glitch must be rejected
    btn = 1'b1; tick(3); btn = 1'b0; tick(10);
    chk("glitch_ped_req", int'(ped_req), 0);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_count", int'(req_count), 0);

    // Held press: ped_req rises after the 7th edge
    btn = 1'b1; tick(6);
    chk("lat_edge6_ped_req", int'(ped_req), 0);
    tick(1);
    chk("lat_edge7_ped_req", int'(ped_req), 1);
    chk("lat_edge7_busy", int'(busy), 1);
    chk("lat_edge7_count", int'(req_count), 1);
    tick(3);
    chk("held_ped_req", int'(ped_req), 1);
    chk("held_count", int'(req_count), 1);
    btn = 1'b0; tick(8);
    btn = 1'b1; tick(8);
    chk("pending_absorb_count", int'(req_count), 1);
    chk("pending_absorb_ped_req", int'(ped_req), 1);
    btn = 1'b0; tick(8);

    // Walk served, then press while walk has just fallen
    walk = 1'b1; tick(1);
    chk("walk_ped_req_fall", int'(ped_req), 0);
    chk("walk_busy", int'(busy), 1);
    tick(4);
    walk = 1'b0; btn = 1'b1; tick(1);
    chk("walk_fall_busy", int'(busy), LK_EN ? 1 : 0);
    tick(6);
    chk("post_walk_e7_ped_req", int'(ped_req), LK_EN ? 0 : 1);
    chk("post_walk_e7_count", int'(req_count), LK_EN ? 1 : 2);
    chk("post_walk_e7_busy", int'(busy), 1);
    tick(1);
    chk("post_walk_e8_busy", int'(busy), 1);
    tick(1);
    chk("post_walk_e9_busy", int'(busy), LK_EN ? 0 : 1);
    chk("post_walk_e9_count", int'(req_count), LK_EN ? 1 : 2);
    btn = 1'b0; tick(8);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst2_ped_req", int'(ped_req), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_count", int'(req_count), 0);

    // Press with walk already high goes straight to SERVING
    walk = 1'b1; btn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("walk_press_no_ped_req", int'(ped_req), 0);
    end
    chk("walk_press_busy", int'(busy), 1);
    chk("walk_press_count", int'(req_count), 1);
    btn = 1'b0; walk = 1'b0; tick(20);
    chk("walk_press_idle_busy", int'(busy), 0);

    // 300 press/serve rounds saturate the counter
    for (int i = 0; i < 300; i++) begin
      btn = 1'b1; tick(7);
      btn = 1'b0; walk = 1'b1; tick(1);
      walk = 1'b0; tick(13);
      if (i == 99) chk("count_after_100", int'(req_count), 101);
    end
    chk("count_saturated", int'(req_count), 255);

    btn = 1'b1; tick(7);
    chk("sat_pending_ped_req", int'(ped_req), 1);
    chk("sat_hold_count", int'(req_count), 255);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_pending_ped_req", int'(ped_req), 0);
    chk("rst_pending_count", int'(req_count), 0);
    chk("rst_pending_busy", int'(busy), 0);

    // Button held through reset release is debounced afresh
    tick(6);
    chk("rel_edge6_ped_req", int'(ped_req), 0);
    tick(1);
    chk("rel_edge7_ped_req", int'(ped_req), 1);
    chk("rel_edge7_count", int'(req_count), 1);
    btn = 1'b0; tick(4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
